// File: rtl/mux_scan_if.sv
// Bundle of the sampling-mux signals between a driver and mux_scan_nx1.
//   master : drives data_in/select/mode/enable, observes the registered results
//   slave  : the mux itself
// Ports (slave view):
//   data_in    in  CHANNELS*WIDTH  packed channels, channel k = data_in[k*WIDTH +: WIDTH]
//   select     in  SEL_W           channel index used in direct mode
//   mode       in  1               0 = direct, 1 = scan
//   enable     in  1               sample request
//   data_out   out WIDTH           registered selected channel
//   chan_out   out SEL_W           index of the channel held in data_out
//   valid_out  out 1               data_out/chan_out updated this cycle
//   sel_err    out 1               direct-mode select out of range this cycle
//   frame_done out 1               pulse alongside the last channel of a scan frame
interface mux_scan_if #(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]          select;
  logic                      mode;
  logic                      enable;
  logic [WIDTH-1:0]          data_out;
  logic [SEL_W-1:0]          chan_out;
  logic                      valid_out;
  logic                      sel_err;
  logic                      frame_done;

  modport master (
    output data_in, select, mode, enable,
    input  data_out, chan_out, valid_out, sel_err, frame_done
  );

  modport slave (
    input  data_in, select, mode, enable,
    output data_out, chan_out, valid_out, sel_err, frame_done
  );
endinterface

// File: rtl/mux_scan_nx1.sv
// N-to-1 sampling multiplexer with a direct (indexed) mode and a scan mode that
// walks channels 0..CHANNELS-1 one per enabled clock.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  mux_scan_if.slave  data/control inputs and registered outputs
module mux_scan_nx1 #(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1
) (
  input  logic      clk,
  input  logic      rst,
  mux_scan_if.slave bus
);
  localparam int SEL_W  = $clog2(CHANNELS);
  localparam int SEL_W1 = SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
  // One bit wider than SEL_W so the range check also works when CHANNELS is a power of two.
  localparam logic [SEL_W:0]   CHAN_CNT = SEL_W1'(CHANNELS);

  typedef enum logic [0:0] {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] data_r, data_next_s;
  logic [SEL_W-1:0] chan_r, chan_next_s;
  logic [SEL_W-1:0] scan_idx_r, scan_idx_next_s;
  logic [SEL_W-1:0] scan_pos_s;
  logic             valid_r, valid_next_s;
  logic             sel_err_r, sel_err_next_s;
  logic             frame_done_r, frame_done_next_s;

  // Loop-based mux keeps every part-select in range, even for indices past CHANNELS-1.
  function automatic logic [WIDTH-1:0] pick_channel(
    input logic [CHANNELS*WIDTH-1:0] vec,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] ch;
    ch = {WIDTH{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      ch = (SEL_W'(k) == idx) ? vec[k*WIDTH +: WIDTH] : ch;
    end
    return ch;
  endfunction

  // Next-state and next-output decode; the state simply follows the sampled mode.
  always_comb begin
    state_next_s      = bus.mode ? ST_SCAN : ST_DIRECT;
    data_next_s       = data_r;
    chan_next_s       = chan_r;
    scan_idx_next_s   = scan_idx_r;
    valid_next_s      = 1'b0;
    sel_err_next_s    = 1'b0;
    frame_done_next_s = 1'b0;
    // Entering scan from direct starts the frame at channel 0 on this very edge.
    scan_pos_s        = (state_r == ST_SCAN) ? scan_idx_r : {SEL_W{1'b0}};

    case (state_next_s)
      ST_SCAN: begin
        if (bus.enable) begin
          data_next_s  = pick_channel(bus.data_in, scan_pos_s);
          chan_next_s  = scan_pos_s;
          valid_next_s = 1'b1;
          // Explicit wrap so non-power-of-two channel counts never overrun.
          if (scan_pos_s == LAST_IDX) begin
            scan_idx_next_s   = {SEL_W{1'b0}};
            frame_done_next_s = 1'b1;
          end else begin
            scan_idx_next_s = scan_pos_s + 1'b1;
          end
        end else begin
          scan_idx_next_s = scan_pos_s;
        end
      end
      ST_DIRECT: begin
        // Any partial scan frame is abandoned on leaving scan mode.
        scan_idx_next_s = {SEL_W{1'b0}};
        if (bus.enable) begin
          if ({1'b0, bus.select} < CHAN_CNT) begin
            data_next_s  = pick_channel(bus.data_in, bus.select);
            chan_next_s  = bus.select;
            valid_next_s = 1'b1;
          end else begin
            sel_err_next_s = 1'b1;
          end
        end else begin
          valid_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s    = ST_DIRECT;
        scan_idx_next_s = {SEL_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_DIRECT;
      data_r       <= {WIDTH{1'b0}};
      chan_r       <= {SEL_W{1'b0}};
      scan_idx_r   <= {SEL_W{1'b0}};
      valid_r      <= 1'b0;
      sel_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      data_r       <= data_next_s;
      chan_r       <= chan_next_s;
      scan_idx_r   <= scan_idx_next_s;
      valid_r      <= valid_next_s;
      sel_err_r    <= sel_err_next_s;
      frame_done_r <= frame_done_next_s;
    end
  end

  assign bus.data_out   = data_r;
  assign bus.chan_out   = chan_r;
  assign bus.valid_out  = valid_r;
  assign bus.sel_err    = sel_err_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: doc/mux_scan_nx1.md
MUX_SCAN_NX1 -- requirements
Module: mux_scan_nx1

Interface
REQ-001 Parameter: CHANNELS, 16, number of input channels (2..256).
REQ-002 Parameter: WIDTH, 1, bits per channel.
REQ-003 Derived localparam: SEL_W, $clog2(CHANNELS), select/index width.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: data_in  input  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
REQ-007 Port: select  input  SEL_W  channel index used in direct mode.
REQ-008 Port: mode  input  1  0 = direct, 1 = scan.
REQ-009 Port: enable  input  1  sample request; no capture when low.
REQ-010 Port: data_out  output  WIDTH  registered selected channel.
REQ-011 Port: chan_out  output  SEL_W  index of the channel currently in data_out.
REQ-012 Port: valid_out  output  1  data_out/chan_out updated this cycle.
REQ-013 Port: sel_err  output  1  direct-mode select >= CHANNELS this cycle.
REQ-014 Port: frame_done  output  1  one-cycle pulse with last channel of a scan frame.

Function
REQ-015 FSM states DIRECT and SCAN; state follows mode sampled at each rising edge.
REQ-016 DIRECT, enable=1, select<CHANNELS: next edge loads data_out=channel[select], chan_out=select, valid_out=1, sel_err=0.
REQ-017 DIRECT, enable=1, select>=CHANNELS: data_out and chan_out hold, valid_out=0, sel_err=1 for that cycle.
REQ-018 Latency: one clock from sampled select/data_in to data_out.
REQ-019 SCAN: internal counter scan_idx; each enable=1 edge loads data_out=channel[scan_idx], chan_out=scan_idx, valid_out=1, then scan_idx increments.
REQ-020 SCAN wrap: when scan_idx=CHANNELS-1 is output, scan_idx returns to 0 and frame_done=1 in the same cycle as that valid_out.
REQ-021 Non-power-of-two CHANNELS: scan_idx never exceeds CHANNELS-1.
REQ-022 enable=0 (either state): data_out, chan_out, scan_idx hold; valid_out=0, frame_done=0, sel_err=0.
REQ-023 DIRECT->SCAN transition (mode 0->1 at an edge): scan_idx forced to 0; first SCAN output on that same edge is channel 0 if enable=1.
REQ-024 SCAN->DIRECT transition mid-frame: scan abandoned, no frame_done, scan_idx cleared to 0; direct output on that edge per REQ-016/017.
REQ-025 select ignored in SCAN; sel_err=0 in SCAN.
REQ-026 valid_out, frame_done, sel_err are single-cycle flags, registered, never combinational from inputs.
REQ-027 data_in sampled only at the loading edge; changes between edges do not affect data_out.

Reset
REQ-028 rst=1 immediately (asynchronously) forces data_out=0, chan_out=0, valid_out=0, sel_err=0, frame_done=0, scan_idx=0, state=DIRECT.
REQ-029 Reset mid-frame discards the frame; after release with mode=1, scan restarts at channel 0.
REQ-030 First edge after rst deasserts behaves as a normal edge (no dead cycle).

Verification
REQ-031 CHANNELS=16, WIDTH=1, DIRECT, data_in=16'b0000100111101110, select=1 -> next edge data_out=1, chan_out=1, valid_out=1; select=0 -> data_out=0.
REQ-032 CHANNELS=4, WIDTH=8, mode=1, enable=1, data_in={8'hD4,8'hC3,8'hB2,8'hA1} -> data_out A1,B2,C3,D4,A1 on consecutive edges; frame_done=1 only with D4.
REQ-033 CHANNELS=12, DIRECT, select=4'd13 -> sel_err=1, valid_out=0, data_out unchanged; SCAN runs 0..11 then wraps to 0.
REQ-034 CHANNELS=4 scan, enable low for 3 cycles after channel 1 -> outputs hold, valid_out=0; resume yields channel 2.
REQ-035 rst asserted between edges during scan at channel 2 -> outputs 0 before next edge; after release, first output is channel 0.
REQ-036 Mode 1->0 at channel 2 of 4 with select=3 -> next output channel 3, frame_done never pulses; mode back to 1 -> restarts at channel 0.
